// File: rtl/hexdisp_if.sv
// Bus between requesters and the hex-display arbiter: requests, urgency, data
// slices in; one-hot grant, encoded owner and the selected display word out.
interface hexdisp_if;
  logic [3:0]  req;
  logic [3:0]  urgent;
  logic [63:0] data_in;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        valid;
  logic [15:0] dataword;

  modport master (
    output req, urgent, data_in,
    input  grant, owner, valid, dataword
  );

  modport slave (
    input  req, urgent, data_in,
    output grant, owner, valid, dataword
  );
endinterface

// File: rtl/hexdisp_arbiter.sv
// Round-robin arbiter for the four-digit hex display: minimum dwell per owner,
// urgent preemption, and a one-cycle break-before-make gap on every handover.
module hexdisp_arbiter #(
  parameter int          DWELL     = 100_000_000,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input logic       clk,
  input logic       rst_n,
  hexdisp_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ARB  = 2'd2
  } state_t;

  localparam logic [26:0] DWELL_LAST = 27'(DWELL - 1);

  state_t      state_r, state_s;
  logic [3:0]  grant_r, grant_s;
  logic [1:0]  owner_r, owner_s;
  logic        valid_r, valid_s;
  logic [15:0] dataword_r, dataword_s;
  logic [26:0] dwell_r, dwell_s;

  logic [3:0]  urg_req_s;
  logic [3:0]  cand_s;
  logic [1:0]  winner_s;
  logic [3:0]  others_s;
  logic [3:0]  other_urg_s;
  logic        owner_req_s;
  logic        owner_urg_s;
  logic        dwell_done_s;

  // First set bit of cand, searching upward from last+1 and wrapping.
  function automatic logic [1:0] pick(input logic [3:0] cand, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && cand[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] slice16(input logic [63:0] d, input logic [1:0] i);
    return d[{i, 4'b0000} +: 16];
  endfunction

  // Selection and SHOW exit qualifiers.
  always_comb begin
    urg_req_s    = bus.req & bus.urgent;
    cand_s       = (urg_req_s != 4'b0000) ? urg_req_s : bus.req;
    winner_s     = pick(cand_s, owner_r);
    others_s     = bus.req & ~grant_r;
    other_urg_s  = urg_req_s & ~grant_r;
    owner_req_s  = bus.req[owner_r];
    owner_urg_s  = urg_req_s[owner_r];
    dwell_done_s = (dwell_r >= DWELL_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 4'b0000) state_s = SHOW;
        else                    state_s = IDLE;
      end
      SHOW: begin
        if (!owner_req_s)                                  state_s = ARB;
        else if ((other_urg_s != 4'b0000) && !owner_urg_s) state_s = ARB;
        else if (dwell_done_s && (others_s != 4'b0000))    state_s = ARB;
        else                                               state_s = SHOW;
      end
      ARB: begin
        if (cand_s != 4'b0000) state_s = SHOW;
        else                   state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and dwell counter.
  always_comb begin
    grant_s    = grant_r;
    owner_s    = owner_r;
    valid_s    = valid_r;
    dataword_s = dataword_r;
    dwell_s    = dwell_r;
    case (state_r)
      IDLE, ARB: begin
        if (state_s == SHOW) begin
          grant_s    = 4'b0001 << winner_s;
          owner_s    = winner_s;
          valid_s    = 1'b1;
          dataword_s = slice16(bus.data_in, winner_s);
          dwell_s    = 27'd0;
        end else begin
          grant_s    = 4'b0000;
          valid_s    = 1'b0;
          dataword_s = IDLE_WORD;
        end
      end
      SHOW: begin
        dataword_s = slice16(bus.data_in, owner_r);
        dwell_s    = dwell_done_s ? DWELL_LAST : (dwell_r + 27'd1);
        if (state_s == ARB) begin
          grant_s = 4'b0000;
          valid_s = 1'b0;
        end else begin
          grant_s = grant_r;
          valid_s = valid_r;
        end
      end
      default: begin
        grant_s    = 4'b0000;
        valid_s    = 1'b0;
        dataword_s = IDLE_WORD;
        dwell_s    = 27'd0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r    <= 4'b0000;
      owner_r    <= 2'd3;
      valid_r    <= 1'b0;
      dataword_r <= IDLE_WORD;
      dwell_r    <= 27'd0;
    end else begin
      grant_r    <= grant_s;
      owner_r    <= owner_s;
      valid_r    <= valid_s;
      dataword_r <= dataword_s;
      dwell_r    <= dwell_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.owner    = owner_r;
  assign bus.valid    = valid_r;
  assign bus.dataword = dataword_r;

endmodule
